prog_sram_writer: RTL

//  Consumes the byte-write stream (adr/data/1-cycle write strobe) from the UART program

---
 rtl/prog_sram_writer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_sram_writer.sv
// ---------------------------------------------------------------------------
// prog_sram_writer
//
// Takes the byte-write stream from the UART program loader and commits it
// to an external asynchronous SRAM.
//
// Incoming bytes are queued in a small FIFO. The block then requests the
// shared SRAM bus and, once it has the grant, generates SRAM write cycles
// in the order SETUP / PULSE / HOLD. It also keeps a byte count and an
// 8-bit additive checksum of the completed writes, so the host can check
// the download.
//
// Parameters
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries of {adr, data}
//   WE_CYCLES    number of cycles sram_we_n is held low per write (>= 1)
//
// Ports
//   clk          system clock; all state changes happen on the rising edge
//   reset        synchronous, active-high reset
//   in_adr       byte address from the loader, sampled when in_write = 1
//   in_data      byte data from the loader, sampled when in_write = 1
//   in_write     one-cycle write strobe from the loader
//   bus_req      SRAM bus request; high in every state except IDLE
//   bus_gnt      grant from the SRAM arbiter
//   sram_adr     SRAM address
//   sram_dq_out  SRAM write data
//   sram_dq_oe   drive enable for the SRAM data pins
//   sram_ce_n    SRAM chip enable, active low
//   sram_we_n    SRAM write enable, active low
//   busy         FIFO non-empty or FSM not idle (combinational)
//   overflow     sticky flag: a strobe arrived while the FIFO was full
//   byte_count   completed SRAM writes, wraps mod 2**21
//   checksum     sum mod 256 of the data of completed SRAM writes
// ---------------------------------------------------------------------------
module prog_sram_writer #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [20:0] in_adr,
    input  logic [7:0]  in_data,
    input  logic        in_write,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [20:0] sram_adr,
    output logic [7:0]  sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_we_n,
    output logic        busy,
    output logic        overflow,
    output logic [20:0] byte_count,
    output logic [7:0]  checksum
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = 29;
    localparam int PW     = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [PW-1:0]         PULSE_LAST = PW'(WE_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0]   FIFO_FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    fifo_head;

    logic [PW-1:0]         pulse_cnt;

    logic                  bus_req_d;
    logic                  sram_ce_n_d;
    logic                  sram_we_n_d;
    logic                  sram_dq_oe_d;

    // FIFO status. The count has one extra bit so that "full" and "empty"
    // are different values even though the pointers wrap.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
    assign fifo_head  = fifo_mem[rd_ptr];

    // A pop moves the FIFO head into the SRAM address/data registers. This
    // happens on the grant in REQ, or at HOLD exit when more data is waiting
    // and the grant is still held. bus_gnt is not looked at anywhere else,
    // so dropping it during a write does not abort that write.
    assign pop = bus_gnt && !fifo_empty && ((state == REQ) || (state == HOLD));

    // A strobe into a full FIFO is still accepted if a pop frees a slot in
    // the same cycle.
    assign push = in_write && (!fifo_full || pop);

    assign busy = !fifo_empty || (state != IDLE);

    // FIFO storage. It is not reset, because an entry is only read after it
    // has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_adr, in_data};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag. A push and a
    // pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (in_write && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM state register. Reset takes effect at once, so a write in
    // progress is abandoned at the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counts the cycles spent in PULSE. It is cleared in every other state,
    // so each PULSE phase starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || (state != PULSE)) begin
            pulse_cnt <= '0;
        end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

    // Next-state logic. A strobe arriving on the same edge as the HOLD exit
    // does not count toward that decision, because the decision uses the
    // registered FIFO count.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (pop) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = PULSE;
            end
            PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (pop) begin
                    next_state = SETUP;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. Pin levels are worked out from the state being entered,
    // then registered, so the SRAM control pins change exactly on the edge
    // where the state changes and never glitch.
    always_comb begin
        bus_req_d    = 1'b0;
        sram_ce_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;
        sram_dq_oe_d = 1'b0;
        case (next_state)
            IDLE: begin
                bus_req_d = 1'b0;
            end
            REQ: begin
                bus_req_d = 1'b1;
            end
            SETUP: begin
                bus_req_d    = 1'b1;
                sram_ce_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
            end
            PULSE: begin
                bus_req_d    = 1'b1;
                sram_ce_n_d  = 1'b0;
                sram_we_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
            end
            HOLD: begin
                bus_req_d    = 1'b1;
                sram_ce_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
            end
            default: begin
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Registered SRAM control pins and bus request.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req    <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            bus_req    <= bus_req_d;
            sram_ce_n  <= sram_ce_n_d;
            sram_we_n  <= sram_we_n_d;
            sram_dq_oe <= sram_dq_oe_d;
        end
    end

    // SRAM address and data are loaded only on a pop edge. That edge always
    // enters SETUP, so both values are stable for the whole of PULSE and
    // HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_adr    <= '0;
            sram_dq_out <= '0;
        end else if (pop) begin
            sram_adr    <= fifo_head[28:8];
            sram_dq_out <= fifo_head[7:0];
        end
    end

    // Download statistics. A write counts as complete when HOLD exits, and
    // HOLD always lasts exactly one cycle. Both counters wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count <= '0;
            checksum   <= '0;
        end else if (state == HOLD) begin
            byte_count <= byte_count + 1'b1;
            checksum   <= checksum + sram_dq_out;
        end
    end

endmodule
